result_fifo: RTL and testbench

Output result buffer directly downstream of the convolution controller/datapath. It captures one datapath result per controller write command (`fifo_command = 2'b10`) into a circular buffer. On a read command (`2'b01`) it enters drain mode and streams every stored result to the external reader under a valid/ready handshake, with `MEM_READ` as ready. Commands are edge-detected, because the controller holds `fifo_command` as a registered level for one or more cycles.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/result_fifo_mem.sv | 28 ++
 rtl/result_fifo.sv | 135 +++++++++++++
 tb/tb_result_fifo.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the convolution controller and its result buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

   // Result word width produced by the convolution datapath.
   localparam int RESULT_DATA_W = 20;

   // Controller-to-buffer command encoding, held as a registered level.
   localparam logic [1:0] FIFO_CMD_IDLE  = 2'b00;
   localparam logic [1:0] FIFO_CMD_READ  = 2'b01;
   localparam logic [1:0] FIFO_CMD_WRITE = 2'b10;
   localparam logic [1:0] FIFO_CMD_RSVD  = 2'b11;

   // Result buffer drain FSM.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } drain_state_t;

endpackage

// File: rtl/result_fifo_mem.sv
// result_fifo_mem: DEPTH x DATA_W register array, one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after wr_en; read is combinational.
// Backpressure: none; the owner decides when writes happen.
module result_fifo_mem #(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is deliberately not reset; occupancy tracking makes stale words invisible.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/result_fifo.sv
// result_fifo: circular result buffer; one push per controller write edge, drains everything on a read edge.
// Latency: pushed word appears on rd_data one cycle after the write edge; rd_valid rises one cycle after the read edge.
// Backpressure: MEM_READ low holds the head stable; a write while full (and not popping) is dropped and sets sticky overflow.
// Build option: define RESULT_FIFO_RELU_EN to clamp negative results to zero on push.
module result_fifo
   import conv_pkg::*;
#(
   parameter int DATA_W = RESULT_DATA_W,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        fifo_command,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              MEM_READ,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              draining,
   output logic              drain_done,
   output logic              overflow
);

   logic [1:0]        cmd_q;
   drain_state_t      state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic              overflow_q;
   logic              wr_evt;
   logic              rd_evt;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] store_data;
   logic [DATA_W-1:0] head_data;

   // The controller holds a command for several cycles; only its first cycle counts.
   assign wr_evt = (fifo_command == FIFO_CMD_WRITE) && (cmd_q != FIFO_CMD_WRITE);
   assign rd_evt = (fifo_command == FIFO_CMD_READ)  && (cmd_q != FIFO_CMD_READ);

   // Occupancy flags come straight from the count register.
   assign empty = (count_q == '0);
   // DEPTH is a power of two and count never exceeds it, so the MSB alone means full.
   assign full  = count_q[ADDR_W];
   assign count = count_q;

   assign draining = (state == ST_DRAIN);
   assign rd_valid = draining && !empty;
   assign pop      = rd_valid && MEM_READ;
   // A pop in the same cycle frees the slot, so a write while full is still accepted.
   assign push     = wr_evt && (!full || pop);

   // A late write keeps the drain alive, so completion waits for a quiet empty cycle.
   assign drain_done = draining && empty && !push;

`ifdef RESULT_FIFO_RELU_EN
   assign store_data = wr_data[DATA_W-1] ? '0 : wr_data;
`else
   assign store_data = wr_data;
`endif

   // Head word is masked while empty so stale array contents never leak out.
   assign rd_data = empty ? '0 : head_data;

   result_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (store_data),
      .rd_addr (rd_ptr),
      .rd_data (head_data)
   );

   // Previous command level for edge detection; the reserved code is tracked like any other.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_q <= FIFO_CMD_IDLE;
      end else begin
         cmd_q <= fifo_command;
      end
   end

   // Pointers wrap naturally at DEPTH; count moves only when exactly one of push/pop happens.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Drain FSM: a read edge starts a drain, a read edge during a drain is ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (rd_evt)     state <= ST_DRAIN;
            ST_DRAIN: if (drain_done) state <= ST_IDLE;
            default:                  state <= ST_IDLE;
         endcase
      end
   end

   // Dropped-write flag stays set until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else if (wr_evt && !push) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;

endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: scoreboard bench for result_fifo (write edges, drains, stalls, overflow, reset).
// Latency: n/a.
// Backpressure: bench drives MEM_READ patterns directly.
module tb_result_fifo;

   localparam int DATA_W = 20;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [1:0]        fifo_command = 2'b00;
   logic [DATA_W-1:0] wr_data = '0;
   logic              MEM_READ = 1'b0;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              draining;
   logic              drain_done;
   logic              overflow;

   int errors = 0;
   int checks = 0;
   int model_cnt = 0;
   logic [DATA_W-1:0] exp_q[$];

   result_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .fifo_command (fifo_command),
      .wr_data      (wr_data),
      .MEM_READ     (MEM_READ),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .draining     (draining),
      .drain_done   (drain_done),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Value the buffer is expected to store for a given input word.
   function automatic logic [DATA_W-1:0] exp_store(input logic [DATA_W-1:0] v);
`ifdef RESULT_FIFO_RELU_EN
      return v[DATA_W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle write pulse followed by one idle cycle; scoreboard updated if the model has room.
   task automatic write_word(input logic [DATA_W-1:0] v);
      fifo_command = 2'b10;
      wr_data = v;
      if (model_cnt < DEPTH) begin
         exp_q.push_back(exp_store(v));
         model_cnt++;
      end
      tick();
      fifo_command = 2'b00;
      tick();
   endtask

   // Request a drain with MEM_READ high and compare every delivered word with the scoreboard.
   task automatic drain_all(input int budget, input string tag);
      bit done;
      logic [DATA_W-1:0] e;
      done = 1'b0;
      fifo_command = 2'b01;
      MEM_READ = 1'b1;
      #1;
      for (int i = 0; i < budget && !done; i++) begin
         if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s_extra: actual=%h required=no word", tag, rd_data);
            end else begin
               e = exp_q.pop_front();
               model_cnt--;
               if (rd_data !== e) begin
                  errors++;
                  $display("FAIL %s_data: actual=%h required=%h", tag, rd_data, e);
               end
            end
         end
         if (drain_done === 1'b1) done = 1'b1;
         else tick();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout: actual=no drain_done required=drain_done within %0d cycles", tag, budget);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing: actual=%0d words left required=0", tag, exp_q.size());
         exp_q.delete();
         model_cnt = 0;
      end
      fifo_command = 2'b00;
      MEM_READ = 1'b0;
      tick();
      checks++;
      if (draining !== 1'b0 || empty !== 1'b1 || count !== 9'd0) begin
         errors++;
         $display("FAIL %s_end: actual draining=%b empty=%b count=%0d required 0/1/0", tag, draining, empty, count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      checks++;
      if (rd_valid !== 1'b0 || full !== 1'b0 || empty !== 1'b1 || count !== 9'd0) begin
         errors++;
         $display("FAIL reset_flags: actual valid=%b full=%b empty=%b count=%0d required 0/0/1/0", rd_valid, full, empty, count);
      end
      checks++;
      if (draining !== 1'b0 || drain_done !== 1'b0 || overflow !== 1'b0 || rd_data !== 20'h0) begin
         errors++;
         $display("FAIL reset_ctrl: actual draining=%b done=%b ovf=%b rd_data=%h required 0/0/0/00000", draining, drain_done, overflow, rd_data);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int first_v, last_v, n_v, n_done, done_at;
      logic [DATA_W-1:0] e;
      first_v = -1; last_v = -1; n_v = 0; n_done = 0; done_at = -1;
      write_word(20'h00011);
      checks++;
      if (rd_data !== 20'h00011 || count !== 9'd1 || rd_valid !== 1'b0 || empty !== 1'b0) begin
         errors++;
         $display("FAIL basic_fwft: actual rd_data=%h count=%0d valid=%b empty=%b required 00011/1/0/0", rd_data, count, rd_valid, empty);
      end
      write_word(20'h00022);
      write_word(20'h00033);
      checks++;
      if (count !== 9'd3) begin
         errors++;
         $display("FAIL basic_count: actual=%0d required=3", count);
      end
      fifo_command = 2'b01;
      MEM_READ = 1'b1;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (rd_valid === 1'b1) begin
            n_v++;
            if (first_v < 0) first_v = i;
            last_v = i;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL basic_extra: actual=%h required=no word", rd_data);
            end else begin
               e = exp_q.pop_front();
               model_cnt--;
               if (rd_data !== e) begin
                  errors++;
                  $display("FAIL basic_data: actual=%h required=%h", rd_data, e);
               end
            end
         end
         if (drain_done === 1'b1) begin
            n_done++;
            done_at = i;
         end
         tick();
      end
      checks++;
      if (n_v != 3 || first_v != 1 || last_v != 3) begin
         errors++;
         $display("FAIL basic_timing: actual words=%0d first=%0d last=%0d required 3/1/3", n_v, first_v, last_v);
      end
      checks++;
      if (n_done != 1 || done_at != 4) begin
         errors++;
         $display("FAIL basic_done: actual pulses=%0d at=%0d required 1 at 4", n_done, done_at);
      end
      checks++;
      if (empty !== 1'b1 || draining !== 1'b0) begin
         errors++;
         $display("FAIL basic_end: actual empty=%b draining=%b required 1/0", empty, draining);
      end
      fifo_command = 2'b00;
      MEM_READ = 1'b0;
      tick();
   endtask

   task automatic test_hold_write();
      fifo_command = 2'b10;
      wr_data = 20'h00077;
      exp_q.push_back(exp_store(20'h00077));
      model_cnt++;
      repeat (5) tick();
      fifo_command = 2'b00;
      tick();
      checks++;
      if (count !== 9'd1 || rd_data !== 20'h00077) begin
         errors++;
         $display("FAIL hold_write: actual count=%0d rd_data=%h required 1/00077", count, rd_data);
      end
      drain_all(20, "hold_drain");
   endtask

   task automatic test_overflow();
      logic [DATA_W-1:0] v;
      for (int i = 0; i < DEPTH; i++) begin
         v = DATA_W'(i * 37 + 5);
         write_word(v);
      end
      checks++;
      if (full !== 1'b1 || count !== 9'd256 || overflow !== 1'b0 || empty !== 1'b0) begin
         errors++;
         $display("FAIL fill: actual full=%b count=%0d ovf=%b empty=%b required 1/256/0/0", full, count, overflow, empty);
      end
      write_word(20'h12345);
      checks++;
      if (overflow !== 1'b1 || count !== 9'd256 || full !== 1'b1) begin
         errors++;
         $display("FAIL overflow: actual ovf=%b count=%0d full=%b required 1/256/1", overflow, count, full);
      end
      checks++;
      if (rd_data !== exp_q[0]) begin
         errors++;
         $display("FAIL overflow_head: actual=%h required=%h", rd_data, exp_q[0]);
      end
      drain_all(DEPTH + 20, "wrap_drain");
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: actual=%b required=1", overflow);
      end
   endtask

   task automatic test_stall();
      logic [DATA_W-1:0] hold;
      logic [DATA_W-1:0] e;
      write_word(20'h00101);
      write_word(20'h00202);
      write_word(20'h00303);
      fifo_command = 2'b01;
      MEM_READ = 1'b0;
      tick();
      fifo_command = 2'b00;
      // MEM_READ = 1: pop the first word
      MEM_READ = 1'b1;
      #1;
      e = exp_q.pop_front();
      model_cnt--;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
         errors++;
         $display("FAIL stall_first: actual valid=%b data=%h required 1/%h", rd_valid, rd_data, e);
      end
      tick();
      // MEM_READ = 0, 0: head must hold
      MEM_READ = 1'b0;
      #1;
      hold = rd_data;
      checks++;
      if (hold !== exp_q[0]) begin
         errors++;
         $display("FAIL stall_head: actual=%h required=%h", hold, exp_q[0]);
      end
      tick();
      checks++;
      if (rd_data !== exp_q[0] || rd_valid !== 1'b1 || count !== 9'd2) begin
         errors++;
         $display("FAIL stall_hold1: actual data=%h valid=%b count=%0d required %h/1/2", rd_data, rd_valid, count, exp_q[0]);
      end
      tick();
      checks++;
      if (rd_data !== exp_q[0] || count !== 9'd2) begin
         errors++;
         $display("FAIL stall_hold2: actual data=%h count=%0d required %h/2", rd_data, count, exp_q[0]);
      end
      // MEM_READ = 1 with a write in the same cycle
      MEM_READ = 1'b1;
      fifo_command = 2'b10;
      wr_data = 20'h0000A;
      #1;
      e = exp_q.pop_front();
      exp_q.push_back(exp_store(20'h0000A));
      checks++;
      if (rd_data !== e) begin
         errors++;
         $display("FAIL stall_pop: actual=%h required=%h", rd_data, e);
      end
      tick();
      fifo_command = 2'b00;
      checks++;
      if (count !== 9'd2 || rd_data !== exp_q[0]) begin
         errors++;
         $display("FAIL push_pop: actual count=%0d data=%h required 2/%h", count, rd_data, exp_q[0]);
      end
      drain_all(20, "stall_drain");
   endtask

   task automatic test_empty_drain();
      fifo_command = 2'b01;
      MEM_READ = 1'b0;
      #1;
      checks++;
      if (drain_done !== 1'b0 || draining !== 1'b0) begin
         errors++;
         $display("FAIL empty_pre: actual done=%b draining=%b required 0/0", drain_done, draining);
      end
      tick();
      checks++;
      if (draining !== 1'b1 || drain_done !== 1'b1 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL empty_drain: actual draining=%b done=%b valid=%b required 1/1/0", draining, drain_done, rd_valid);
      end
      tick();
      checks++;
      if (draining !== 1'b0 || drain_done !== 1'b0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL empty_after: actual draining=%b done=%b valid=%b required 0/0/0", draining, drain_done, rd_valid);
      end
      tick();
      checks++;
      if (draining !== 1'b0) begin
         errors++;
         $display("FAIL empty_retrigger: actual draining=%b required 0", draining);
      end
      fifo_command = 2'b00;
      tick();
   endtask

   task automatic test_relu();
      write_word(20'hFFFFF);
      write_word(20'h00005);
      write_word(20'h80000);
      write_word(20'h7FFFF);
      drain_all(20, "relu_drain");
   endtask

   task automatic test_reset_mid_drain();
      write_word(20'h00100);
      write_word(20'h00200);
      write_word(20'h00300);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_ovf: actual=%b required=1", overflow);
      end
      fifo_command = 2'b01;
      MEM_READ = 1'b0;
      tick();
      fifo_command = 2'b00;
      MEM_READ = 1'b1;
      #1;
      checks++;
      if (rd_valid !== 1'b1 || draining !== 1'b1) begin
         errors++;
         $display("FAIL mid_drain: actual valid=%b draining=%b required 1/1", rd_valid, draining);
      end
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || full !== 1'b0 || empty !== 1'b1 || count !== 9'd0 || rd_data !== 20'h0) begin
         errors++;
         $display("FAIL async_reset_data: actual valid=%b full=%b empty=%b count=%0d rd_data=%h required 0/0/1/0/00000", rd_valid, full, empty, count, rd_data);
      end
      checks++;
      if (draining !== 1'b0 || drain_done !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_ctrl: actual draining=%b done=%b ovf=%b required 0/0/0", draining, drain_done, overflow);
      end
      exp_q.delete();
      model_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (drain_done !== 1'b0 || draining !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: actual done=%b draining=%b required 0/0", drain_done, draining);
         end
      end
      MEM_READ = 1'b0;
      reset = 1'b1;
      tick();
      write_word(20'h00042);
      checks++;
      if (count !== 9'd1 || rd_data !== exp_store(20'h00042)) begin
         errors++;
         $display("FAIL post_reset_write: actual count=%0d data=%h required 1/%h", count, rd_data, exp_store(20'h00042));
      end
      drain_all(20, "post_reset_drain");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold_write();
      test_overflow();
      test_stall();
      test_empty_drain();
      test_relu();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
